sc_reg_universal: RTL

Parametrised universal register, successor to the general load/clear register. Adds shift-left, shift-right, rotate-left and rotate-right modes, serial inputs and outputs, and a built-in step prescaler. The prescaler advances the register automatically every PERIOD+1 enabled clocks. Used for scrolling road/obstacle rows and timed patterns, and as a drop-in for plain load/clear registers (mode = hold).

---
 rtl/sc_reg_universal.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sc_reg_universal.sv
// -----------------------------------------------------------------------------
// sc_reg_universal
// Parametrised universal register: hold / shift-left / shift-right /
// rotate-left / rotate-right, with serial in/out and a built-in step
// prescaler that advances the register every period+1 enabled clocks.
// With mode = hold it behaves as a plain load/clear register.
//
// Ports:
//   SC_RegUNIVERSAL_CLOCK_50       system clock, rising edge
//   SC_RegUNIVERSAL_RESET_InLow    asynchronous active-low reset
//   SC_RegUNIVERSAL_clear_InLow    synchronous clear (highest priority)
//   SC_RegUNIVERSAL_load_InLow     synchronous parallel load
//   SC_RegUNIVERSAL_data_InBUS     parallel load data
//   SC_RegUNIVERSAL_mode_InBUS     000 hold, 001 SHL, 010 SHR, 011 ROL,
//                                  100 ROR, 101-111 hold
//   SC_RegUNIVERSAL_serialLSB_In   bit entering bit 0 on SHL
//   SC_RegUNIVERSAL_serialMSB_In   bit entering MSB on SHR
//   SC_RegUNIVERSAL_enable_InHigh  prescaler run enable
//   SC_RegUNIVERSAL_period_InBUS   step every period+1 enabled cycles
//   SC_RegUNIVERSAL_data_OutBUS    register contents (registered)
//   SC_RegUNIVERSAL_serial_Out     bit shifted/rotated out on last step
//   SC_RegUNIVERSAL_step_OutHigh   one-cycle pulse after a step was applied
//
// Optional feature macro: SC_REGUNIVERSAL_ZEROFLAG_EN
//   When defined, adds SC_RegUNIVERSAL_zero_OutHigh, a combinational flag
//   that is high whenever data_OutBUS is all zeros.
// -----------------------------------------------------------------------------
module sc_reg_universal #(
   parameter int RegUNIVERSAL_DATAWIDTH  = 8,
   parameter int RegUNIVERSAL_PRESCWIDTH = 4
) (
   input  logic                                 SC_RegUNIVERSAL_CLOCK_50,
   input  logic                                 SC_RegUNIVERSAL_RESET_InLow,
   input  logic                                 SC_RegUNIVERSAL_clear_InLow,
   input  logic                                 SC_RegUNIVERSAL_load_InLow,
   input  logic [RegUNIVERSAL_DATAWIDTH-1:0]    SC_RegUNIVERSAL_data_InBUS,
   input  logic [2:0]                           SC_RegUNIVERSAL_mode_InBUS,
   input  logic                                 SC_RegUNIVERSAL_serialLSB_In,
   input  logic                                 SC_RegUNIVERSAL_serialMSB_In,
   input  logic                                 SC_RegUNIVERSAL_enable_InHigh,
   input  logic [RegUNIVERSAL_PRESCWIDTH-1:0]   SC_RegUNIVERSAL_period_InBUS,
   output logic [RegUNIVERSAL_DATAWIDTH-1:0]    SC_RegUNIVERSAL_data_OutBUS,
   output logic                                 SC_RegUNIVERSAL_serial_Out,
   output logic                                 SC_RegUNIVERSAL_step_OutHigh
`ifdef SC_REGUNIVERSAL_ZEROFLAG_EN
   ,
   output logic                                 SC_RegUNIVERSAL_zero_OutHigh
`endif
);

   localparam int W  = RegUNIVERSAL_DATAWIDTH;
   localparam int PW = RegUNIVERSAL_PRESCWIDTH;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_ROL  = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;

   logic [W-1:0]  regValue_r;
   logic [PW-1:0] count_r;
   logic          serial_r;
   logic          stepPulse_r;

   logic          stepDue_s;
   logic [W-1:0]  nextValue_s;
   logic          nextSerial_s;

   // Step result as {serial bit out, new register value}; hold modes keep
   // both the register and the previously shifted-out bit.
   function automatic logic [W:0] stepResult(
      input logic [2:0]   mode,
      input logic [W-1:0] value,
      input logic         serialIn,
      input logic         serialLsb,
      input logic         serialMsb
   );
      logic [W:0] res;
      case (mode)
         MODE_SHL: res = {value[W-1], value[W-2:0], serialLsb};
         MODE_SHR: res = {value[0],   serialMsb,    value[W-1:1]};
         MODE_ROL: res = {value[W-1], value[W-2:0], value[W-1]};
         MODE_ROR: res = {value[0],   value[0],     value[W-1:1]};
         MODE_HOLD: res = {serialIn, value};
         default:  res = {serialIn, value};
      endcase
      return res;
   endfunction

   // Step decision and next-state value of the shifter.
   always_comb begin
      stepDue_s                   = 1'b0;
      {nextSerial_s, nextValue_s} = stepResult(SC_RegUNIVERSAL_mode_InBUS, regValue_r,
                                               serial_r,
                                               SC_RegUNIVERSAL_serialLSB_In,
                                               SC_RegUNIVERSAL_serialMSB_In);
      // ">=" so that lowering the period below the current count steps at
      // the next enabled edge instead of waiting for the counter to wrap.
      if (SC_RegUNIVERSAL_enable_InHigh && (count_r >= SC_RegUNIVERSAL_period_InBUS)) begin
         stepDue_s = 1'b1;
      end else begin
         stepDue_s = 1'b0;
      end
   end

   // Register, prescaler and registered outputs with clear > load > step > hold.
   always_ff @(posedge SC_RegUNIVERSAL_CLOCK_50 or negedge SC_RegUNIVERSAL_RESET_InLow) begin
      if (!SC_RegUNIVERSAL_RESET_InLow) begin
         regValue_r  <= {W{1'b0}};
         count_r     <= {PW{1'b0}};
         serial_r    <= 1'b0;
         stepPulse_r <= 1'b0;
      end else if (!SC_RegUNIVERSAL_clear_InLow) begin
         regValue_r  <= {W{1'b0}};
         count_r     <= {PW{1'b0}};
         stepPulse_r <= 1'b0;
      end else if (!SC_RegUNIVERSAL_load_InLow) begin
         regValue_r  <= SC_RegUNIVERSAL_data_InBUS;
         count_r     <= {PW{1'b0}};
         stepPulse_r <= 1'b0;
      end else if (stepDue_s) begin
         regValue_r  <= nextValue_s;
         serial_r    <= nextSerial_s;
         count_r     <= {PW{1'b0}};
         stepPulse_r <= 1'b1;
      end else if (SC_RegUNIVERSAL_enable_InHigh) begin
         // count_r < period here, so the increment cannot overflow.
         count_r     <= count_r + PW'(1);
         stepPulse_r <= 1'b0;
      end else begin
         stepPulse_r <= 1'b0;
      end
   end

   assign SC_RegUNIVERSAL_data_OutBUS  = regValue_r;
   assign SC_RegUNIVERSAL_serial_Out   = serial_r;
   assign SC_RegUNIVERSAL_step_OutHigh = stepPulse_r;

`ifdef SC_REGUNIVERSAL_ZEROFLAG_EN
   assign SC_RegUNIVERSAL_zero_OutHigh = (regValue_r == {W{1'b0}});
`endif

endmodule
